ser_gen: RTL and testbench



---
 rtl/ser_gen.sv | 98 +++++++++
 tb/tb_ser_gen.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ser_gen.sv
// Width-down serializer: one INWIDTH beat out as up to DEPTH OUTWIDTH words, valid/stop handshake.
// Optional sticky bad-count flag (err_out) when SER_GEN_ERRCHK_EN is defined.
module ser_gen #(
   parameter int INWIDTH   = 64,
   parameter int OUTWIDTH  = 16,
   parameter bit MSB_FIRST = 1'b1,
   localparam int DEPTH    = INWIDTH / OUTWIDTH,
   localparam int CW       = $clog2(DEPTH + 1)
) (
   input  logic                clk,
   input  logic                res_n,
   input  logic [INWIDTH-1:0]  wdata,
   input  logic [CW-1:0]       wcount,
   input  logic                valid_in,
   output logic                stop_out,
   output logic [OUTWIDTH-1:0] rdata,
   output logic                valid_out,
   output logic                last_out,
   input  logic                stop_in
`ifdef SER_GEN_ERRCHK_EN
   ,
   output logic                err_out
`endif
);

   generate
      if ((INWIDTH % OUTWIDTH) != 0 || DEPTH < 2) begin : g_bad_cfg
         $fatal(1, "ser_gen: INWIDTH must be a multiple of OUTWIDTH with a ratio of at least 2");
      end
   endgenerate

   logic [DEPTH-1:0][OUTWIDTH-1:0] beat_q;
   logic [CW-1:0]                  idx_q;
   logic [CW-1:0]                  rem_q;
   logic [CW-1:0]                  eff_count;
   logic                           bad_count;
   logic                           accept;
   logic                           xfer;

   assign valid_out = (rem_q != '0);
   assign last_out  = (rem_q == CW'(1));
   // The last word draining makes room for the next beat in the same cycle.
   assign stop_out  = valid_out && !(last_out && !stop_in);
   assign accept    = valid_in && !stop_out;
   assign xfer      = valid_out && !stop_in;

   assign bad_count = (wcount == '0) || (int'(wcount) > DEPTH);

   // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      eff_count = wcount;
      if (bad_count) eff_count = CW'(DEPTH);
   end

   always_comb begin
      rdata = '0;
      if (valid_out) begin
         for (int k = 0; k < DEPTH; k++) begin
            if (idx_q == CW'(MSB_FIRST ? (DEPTH - 1 - k) : k)) rdata = beat_q[k];
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   // NOTE: the beat buffer is cleared on reset so rdata is a defined zero before the first beat.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         beat_q <= '0;
         idx_q  <= '0;
         rem_q  <= '0;
      end else if (accept) begin
         beat_q <= wdata;
         idx_q  <= '0;
         rem_q  <= eff_count;
      end else if (xfer) begin
         idx_q  <= idx_q + CW'(1);
         rem_q  <= rem_q - CW'(1);
      end
   end

`ifdef SER_GEN_ERRCHK_EN
   logic err_q;

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         err_q <= 1'b0;
      end else if (accept && bad_count) begin
         err_q <= 1'b1;
`ifndef SYNTHESIS
         $warning("%m: beat accepted with out-of-range wcount %0d, clamped to %0d", wcount, DEPTH);
`endif
      end
   end

   assign err_out = err_q;
`endif

endmodule

// File: tb/tb_ser_gen.sv
// Bench for ser_gen: three instances (64/16 MSB-first, 64/16 LSB-first, 96/32 MSB-first)
// checked every cycle against a word-queue model, plus hand-computed expectations.
module tb_ser_gen;

   logic clk = 1'b0;
   logic res_n;
   always #5 clk = ~clk;

   logic [95:0] wd [3];
   logic [2:0]  wc [3];
   logic        vi [3];
   logic        si [3];

   logic [15:0] rd0, rd1;
   logic [31:0] rd2;
   wire  [2:0]  vo, lo, so;
`ifdef SER_GEN_ERRCHK_EN
   wire  [2:0]  eo;
`endif

   ser_gen #(.INWIDTH(64), .OUTWIDTH(16), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .res_n(res_n), .wdata(wd[0][63:0]), .wcount(wc[0]), .valid_in(vi[0]),
      .stop_out(so[0]), .rdata(rd0), .valid_out(vo[0]), .last_out(lo[0]), .stop_in(si[0])
`ifdef SER_GEN_ERRCHK_EN
      , .err_out(eo[0])
`endif
   );

   ser_gen #(.INWIDTH(64), .OUTWIDTH(16), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .res_n(res_n), .wdata(wd[1][63:0]), .wcount(wc[1]), .valid_in(vi[1]),
      .stop_out(so[1]), .rdata(rd1), .valid_out(vo[1]), .last_out(lo[1]), .stop_in(si[1])
`ifdef SER_GEN_ERRCHK_EN
      , .err_out(eo[1])
`endif
   );

   ser_gen #(.INWIDTH(96), .OUTWIDTH(32), .MSB_FIRST(1'b1)) u_w96 (
      .clk(clk), .res_n(res_n), .wdata(wd[2]), .wcount(wc[2][1:0]), .valid_in(vi[2]),
      .stop_out(so[2]), .rdata(rd2), .valid_out(vo[2]), .last_out(lo[2]), .stop_in(si[2])
`ifdef SER_GEN_ERRCHK_EN
      , .err_out(eo[2])
`endif
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- model: per instance, the list of words still owed ----------------
   function automatic int dep(int i);    return (i == 2) ? 3 : 4;   endfunction
   function automatic int ow(int i);     return (i == 2) ? 32 : 16; endfunction
   function automatic bit msb(int i);    return (i != 1);           endfunction

   function automatic logic [31:0] word_of(int i, logic [95:0] beat, int k);
      int          slot;
      logic [95:0] sh;
      slot = msb(i) ? (dep(i) - 1 - k) : k;
      sh   = beat >> (slot * ow(i));
      return (i == 2) ? sh[31:0] : {16'h0, sh[15:0]};
   endfunction

   function automatic logic [31:0] act_rd(int i);
      if (i == 0) return {16'h0, rd0};
      if (i == 1) return {16'h0, rd1};
      return rd2;
   endfunction

   logic [31:0] mw [3][4];
   int          mn [3];
   int          mh [3];
   bit          merr [3];

   always @(posedge clk or negedge res_n) begin
      int  rem, w, n;
      bit  stp;
      if (!res_n) begin
         for (int i = 0; i < 3; i++) begin
            mn[i] = 0; mh[i] = 0; merr[i] = 1'b0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            rem = mn[i] - mh[i];
            stp = (rem != 0) && !((rem == 1) && !si[i]);
            if (rem != 0 && !si[i]) mh[i]++;
            if (vi[i] && !stp) begin
               w = (i == 2) ? int'(wc[i][1:0]) : int'(wc[i]);
               n = (w == 0 || w > dep(i)) ? dep(i) : w;
               for (int k = 0; k < n; k++) mw[i][k] = word_of(i, wd[i], k);
               mn[i] = n;
               mh[i] = 0;
               if (w == 0 || w > dep(i)) merr[i] = 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      int rem;
      for (int i = 0; i < 3; i++) begin
         rem = mn[i] - mh[i];
         check($sformatf("valid_out[%0d]", i), vo[i], rem != 0);
         check($sformatf("last_out[%0d]", i),  lo[i], rem == 1);
         check($sformatf("stop_out[%0d]", i),  so[i], (rem != 0) && !((rem == 1) && !si[i]));
         check($sformatf("rdata[%0d]", i), act_rd(i), (rem != 0) ? mw[i][mh[i]] : 32'h0);
`ifdef SER_GEN_ERRCHK_EN
         check($sformatf("err_out[%0d]", i), eo[i], merr[i]);
`endif
      end
   end

   // ---------------- directed stimulus with literal expectations ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      for (int i = 0; i < 3; i++) begin
         wd[i] = '0; wc[i] = '0; vi[i] = 1'b0; si[i] = 1'b0;
      end
   endtask

   task automatic exp0(input string tag, input logic [15:0] r, input logic v, input logic l, input logic s);
      check({tag, "_rdata"}, {16'h0, rd0}, {16'h0, r});
      check({tag, "_valid"}, vo[0], v);
      check({tag, "_last"},  lo[0], l);
      check({tag, "_stop"},  so[0], s);
   endtask

   task automatic load(input int i, input logic [95:0] beat, input logic [2:0] cnt);
      wd[i] = beat; wc[i] = cnt; vi[i] = 1'b1;
      tick();
      vi[i] = 1'b0;
   endtask

   initial begin
      res_n = 1'b1;
      idle_all();
      #2 res_n = 1'b0;
      #1;
      exp0("reset", 16'h0, 1'b0, 1'b0, 1'b0);
      check("reset_rd2", rd2, 32'h0);
      check("reset_valid2", vo[2], 1'b0);
`ifdef SER_GEN_ERRCHK_EN
      check("reset_err0", eo[0], 1'b0);
`endif
      repeat (2) @(posedge clk);
      #1 res_n = 1'b1;
      tick();

      // basic MSB-first, full beat
      wd[0] = 64'h1111_2222_3333_4444; wc[0] = 3'd4; vi[0] = 1'b1;
      check("basic_idle_stop", so[0], 1'b0);
      tick();
      vi[0] = 1'b0;
      exp0("basic_w0", 16'h1111, 1'b1, 1'b0, 1'b1);
      tick(); exp0("basic_w1", 16'h2222, 1'b1, 1'b0, 1'b1);
      tick(); exp0("basic_w2", 16'h3333, 1'b1, 1'b0, 1'b1);
      tick(); exp0("basic_w3", 16'h4444, 1'b1, 1'b1, 1'b0);
      tick(); exp0("basic_done", 16'h0, 1'b0, 1'b0, 1'b0);

      // back-to-back: B held on valid_in while A drains
      wd[0] = 64'h0A01_0A02_0A03_0A04; wc[0] = 3'd4; vi[0] = 1'b1;
      tick();
      wd[0] = 64'h0B01_0B02_0B03_0B04;
      tick(); tick(); tick();
      exp0("b2b_a_last", 16'h0A04, 1'b1, 1'b1, 1'b0);
      tick();
      vi[0] = 1'b0;
      exp0("b2b_b_first", 16'h0B01, 1'b1, 1'b0, 1'b1);
      repeat (4) tick();

      // stall on word 2
      load(0, 64'h1111_2222_3333_4444, 3'd4);
      tick();
      si[0] = 1'b1;
      exp0("stall_enter", 16'h2222, 1'b1, 1'b0, 1'b1);
      for (int c = 0; c < 3; c++) begin
         tick();
         exp0($sformatf("stall_hold%0d", c), 16'h2222, 1'b1, 1'b0, 1'b1);
      end
      si[0] = 1'b0;
      tick(); exp0("stall_resume", 16'h3333, 1'b1, 1'b0, 1'b1);
      tick(); exp0("stall_last", 16'h4444, 1'b1, 1'b1, 1'b0);
      tick();

      // partial beat, LSB-first
      load(1, 64'hAAAA_BBBB_CCCC_DDDD, 3'd2);
      check("lsb_w0", {16'h0, rd1}, 32'h0000_DDDD);
      check("lsb_w0_last", lo[1], 1'b0);
      tick();
      check("lsb_w1", {16'h0, rd1}, 32'h0000_CCCC);
      check("lsb_w1_last", lo[1], 1'b1);
      tick();
      check("lsb_done", vo[1], 1'b0);

      // clamped counts
      load(0, 64'h1111_2222_3333_4444, 3'd5);
      exp0("clamp_w0", 16'h1111, 1'b1, 1'b0, 1'b1);
`ifdef SER_GEN_ERRCHK_EN
      check("clamp_err_set", eo[0], 1'b1);
`endif
      repeat (3) tick();
      exp0("clamp_w3", 16'h4444, 1'b1, 1'b1, 1'b0);
      tick();
      load(0, 64'h1111_2222_3333_4444, 3'd2);
      tick();
      exp0("top2_last", 16'h2222, 1'b1, 1'b1, 1'b0);
`ifdef SER_GEN_ERRCHK_EN
      check("clamp_err_sticky", eo[0], 1'b1);
`endif
      tick();

      // 96/32 ratio, wcount 0 means full beat
      load(2, 96'hAAAAAAAA_BBBBBBBB_CCCCCCCC, 3'd0);
      check("w96_w0", rd2, 32'hAAAA_AAAA);
`ifdef SER_GEN_ERRCHK_EN
      check("w96_err", eo[2], 1'b1);
`endif
      tick(); check("w96_w1", rd2, 32'hBBBB_BBBB);
      tick(); check("w96_w2", rd2, 32'hCCCC_CCCC);
      check("w96_w2_last", lo[2], 1'b1);
      tick(); check("w96_done", vo[2], 1'b0);
      load(2, 96'h11111111_22222222_33333333, 3'd1);
      check("w96_single", rd2, 32'h1111_1111);
      check("w96_single_last", lo[2], 1'b1);
      tick();

      // reset mid-beat
      load(0, 64'h1111_2222_3333_4444, 3'd4);
      tick();
      #2 res_n = 1'b0;
      #1;
      exp0("rst_mid", 16'h0, 1'b0, 1'b0, 1'b0);
`ifdef SER_GEN_ERRCHK_EN
      check("rst_err_clear", eo[0], 1'b0);
`endif
      tick();
      res_n = 1'b1;
      load(0, 64'h5555_6666_7777_8888, 3'd4);
      exp0("rst_new_first", 16'h5555, 1'b1, 1'b0, 1'b1);
      repeat (4) tick();

      // mixed traffic on all instances, checked by the model each cycle
      for (int cyc = 0; cyc < 60; cyc++) begin
         for (int i = 0; i < 3; i++) begin
            vi[i] = ((cyc + i) % 4) != 3;
            si[i] = ((cyc + i) % 5 == 2) || (cyc % 7 == 0);
            wd[i] = {32'(cyc) * 32'h9E37_79B1, 32'(cyc + i) * 32'h85EB_CA6B, 32'(cyc ^ 7) * 32'hC2B2_AE35};
            wc[i] = (i == 2) ? 3'(cyc % 4) : 3'(cyc % 6);
         end
         tick();
      end
      idle_all();
      repeat (6) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
